// File: rtl/tap_controller_pkg.sv
// Shared TAP definitions: 4-bit IEEE 1149.1 state encodings and instruction opcodes.
// Boundary-cell benches import this package too, so the encodings live in one place.
package tap_controller_pkg;

    typedef enum logic [3:0] {
        ST_EX2_DR   = 4'h0,
        ST_EX1_DR   = 4'h1,
        ST_SH_DR    = 4'h2,
        ST_PAUSE_DR = 4'h3,
        ST_SEL_IR   = 4'h4,
        ST_UPD_DR   = 4'h5,
        ST_CAP_DR   = 4'h6,
        ST_SEL_DR   = 4'h7,
        ST_EX2_IR   = 4'h8,
        ST_EX1_IR   = 4'h9,
        ST_SH_IR    = 4'hA,
        ST_PAUSE_IR = 4'hB,
        ST_RTI      = 4'hC,
        ST_UPD_IR   = 4'hD,
        ST_CAP_IR   = 4'hE,
        ST_TLR      = 4'hF
    } tap_state_e;

    localparam logic [3:0] OP_EXTEST = 4'b0000;
    localparam logic [3:0] OP_SAMPLE = 4'b0001;
    localparam logic [3:0] OP_IDCODE = 4'b0010;
    localparam logic [3:0] OP_BYPASS = 4'b1111;

endpackage

// File: rtl/tap_state_fsm.sv
// 16-state TAP controller state machine; advances on posedge TCK under TMS.
module tap_state_fsm
    import tap_controller_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst_n,
    input  logic       i_tms,
    output logic [3:0] o_state
);

    tap_state_e r_state;

    always_ff @(posedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) begin
            r_state <= ST_TLR;
        end else begin
            case (r_state)
                ST_TLR:      r_state <= i_tms ? ST_TLR      : ST_RTI;
                ST_RTI:      r_state <= i_tms ? ST_SEL_DR   : ST_RTI;
                ST_SEL_DR:   r_state <= i_tms ? ST_SEL_IR   : ST_CAP_DR;
                ST_CAP_DR:   r_state <= i_tms ? ST_EX1_DR   : ST_SH_DR;
                ST_SH_DR:    r_state <= i_tms ? ST_EX1_DR   : ST_SH_DR;
                ST_EX1_DR:   r_state <= i_tms ? ST_UPD_DR   : ST_PAUSE_DR;
                ST_PAUSE_DR: r_state <= i_tms ? ST_EX2_DR   : ST_PAUSE_DR;
                ST_EX2_DR:   r_state <= i_tms ? ST_UPD_DR   : ST_SH_DR;
                ST_UPD_DR:   r_state <= i_tms ? ST_SEL_DR   : ST_RTI;
                ST_SEL_IR:   r_state <= i_tms ? ST_TLR      : ST_CAP_IR;
                ST_CAP_IR:   r_state <= i_tms ? ST_EX1_IR   : ST_SH_IR;
                ST_SH_IR:    r_state <= i_tms ? ST_EX1_IR   : ST_SH_IR;
                ST_EX1_IR:   r_state <= i_tms ? ST_UPD_IR   : ST_PAUSE_IR;
                ST_PAUSE_IR: r_state <= i_tms ? ST_EX2_IR   : ST_PAUSE_IR;
                ST_EX2_IR:   r_state <= i_tms ? ST_UPD_IR   : ST_SH_IR;
                ST_UPD_IR:   r_state <= i_tms ? ST_SEL_DR   : ST_RTI;
                default:     r_state <= ST_TLR;
            endcase
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/tap_controller.sv
// JTAG TAP: IR, bypass/IDCODE data registers, boundary-chain strobes and TDO mux.
// Shift registers move on posedge TCK; active IR and TDO change on negedge TCK.
module tap_controller
    import tap_controller_pkg::*;
#(
    parameter int          IR_LENGTH    = 4,
    parameter logic [31:0] IDCODE_VALUE = 32'h1234_5679
) (
    input  logic TCK,
    input  logic TRST,
    input  logic TMS,
    input  logic TDI,
    input  logic BSChainTDO,
    output logic TDO,
    output logic TDO_en,
    output logic CaptureDR,
    output logic ShiftDR,
    output logic UpdateDR,
    output logic extest
);

    // Capture-IR pattern: ...0101, so the LSB shifted out first is always 1.
    function automatic logic [IR_LENGTH-1:0] ir_capture_pat();
        logic [IR_LENGTH-1:0] v;
        for (int i = 0; i < IR_LENGTH; i++) v[i] = (i % 2 == 0);
        return v;
    endfunction

    logic [3:0]           w_state;
    logic [IR_LENGTH-1:0] r_ir_sh;
    logic [IR_LENGTH-1:0] r_ir;
    logic                 r_bypass;
    logic [31:0]          r_idreg;
    logic                 w_sel_bs;
    logic                 w_sel_id;
    logic                 w_dr_tdo;

    tap_state_fsm u_fsm (
        .i_tck    (TCK),
        .i_trst_n (TRST),
        .i_tms    (TMS),
        .o_state  (w_state)
    );

    // Unknown opcodes fall through to the bypass register.
    assign w_sel_bs = (r_ir == IR_LENGTH'(OP_EXTEST)) || (r_ir == IR_LENGTH'(OP_SAMPLE));
    assign w_sel_id = (r_ir == IR_LENGTH'(OP_IDCODE));
    assign w_dr_tdo = w_sel_bs ? BSChainTDO : (w_sel_id ? r_idreg[0] : r_bypass);

    assign CaptureDR = w_sel_bs && (w_state == ST_CAP_DR);
    assign ShiftDR   = w_sel_bs && (w_state == ST_SH_DR);
    assign UpdateDR  = w_sel_bs && (w_state == ST_UPD_DR);
    assign extest    = (r_ir == IR_LENGTH'(OP_EXTEST));

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_ir_sh <= '0;
        end else if (w_state == ST_CAP_IR) begin
            r_ir_sh <= ir_capture_pat();
        end else if (w_state == ST_SH_IR) begin
            r_ir_sh <= {TDI, r_ir_sh[IR_LENGTH-1:1]};
        end
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_ir <= IR_LENGTH'(OP_IDCODE);
        end else if (w_state == ST_TLR) begin
            r_ir <= IR_LENGTH'(OP_IDCODE);
        end else if (w_state == ST_UPD_IR) begin
            r_ir <= r_ir_sh;
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            r_bypass <= 1'b0;
            r_idreg  <= IDCODE_VALUE;
        end else if (w_state == ST_CAP_DR) begin
            r_bypass <= 1'b0;
            r_idreg  <= IDCODE_VALUE;
        end else if (w_state == ST_SH_DR) begin
            if (w_sel_id) begin
                r_idreg <= {TDI, r_idreg[31:1]};
            end else if (!w_sel_bs) begin
                r_bypass <= TDI;
            end
        end
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            TDO    <= 1'b0;
            TDO_en <= 1'b0;
        end else begin
            TDO_en <= (w_state == ST_SH_IR) || (w_state == ST_SH_DR);
            if (w_state == ST_SH_IR)      TDO <= r_ir_sh[0];
            else if (w_state == ST_SH_DR) TDO <= w_dr_tdo;
            else                          TDO <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tap_controller.sv
// Bench for tap_controller: expected TDO bits queued as shifts are driven,
// popped whenever the DUT drives TDO_en; strobes and extest checked per cycle.
module tb_tap_controller;

    logic TCK, TRST, TMS, TDI, BSChainTDO;
    logic TDO, TDO_en, CaptureDR, ShiftDR, UpdateDR, extest;

    tap_controller #(.IR_LENGTH(4), .IDCODE_VALUE(32'h1234_5679)) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .BSChainTDO (BSChainTDO),
        .TDO        (TDO),
        .TDO_en     (TDO_en),
        .CaptureDR  (CaptureDR),
        .ShiftDR    (ShiftDR),
        .UpdateDR   (UpdateDR),
        .extest     (extest)
    );

    localparam logic [31:0] IDCODE = 32'h1234_5679;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];
    string       sb_tag = "tdo";
    logic        m_ext, m_cap, m_sh, m_upd;
    int          cnt_cap, cnt_sh, cnt_upd;
    logic        exp_ext = 1'b0;

    initial TCK = 1'b0;
    always #5 TCK = ~TCK;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One TCK: drive inputs, sample strobes after posedge, TDO after negedge.
    task automatic tick(input logic tms, input logic tdi, input logic bsc);
        TMS = tms; TDI = tdi; BSChainTDO = bsc;
        @(posedge TCK); #1;
        m_ext = extest; m_cap = CaptureDR; m_sh = ShiftDR; m_upd = UpdateDR;
        cnt_cap += int'(m_cap); cnt_sh += int'(m_sh); cnt_upd += int'(m_upd);
        @(negedge TCK); #1;
        if (TDO_en) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk(sb_tag, 32'(TDO), sb.pop_front());
        end
    endtask

    // RTI -> shift op into IR -> Update-IR -> RTI; captured 0101 comes out first.
    task automatic load_ir(input logic [3:0] op);
        logic [3:0] cap;
        cap = 4'b0101;
        sb_tag = "ir_capture";
        for (int i = 0; i < 4; i++) sb.push_back(32'(cap[i]));
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        for (int i = 0; i < 4; i++) tick(i == 3, op[i], 0);
        tick(1, 0, 0);
        chk("extest_before_upd_negedge", 32'(m_ext), 32'(exp_ext));
        exp_ext = (op == 4'b0000);
        chk("extest_after_upd_negedge", 32'(extest), 32'(exp_ext));
        tick(0, 0, 0);
        chk("state_rti_after_ir", 32'(dut.w_state), 32'hC);
    endtask

    // RTI -> Capture-DR -> n outputs in Shift-DR -> Update-DR -> RTI.
    task automatic dr_scan(input int n, input logic [31:0] tdi, input logic [31:0] bsc);
        logic b;
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
        tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, bsc[0]);
        for (int i = 0; i < n; i++) begin
            b = 1'(bsc >> (i + 1));
            tick(i == n - 1, tdi[i], b);
        end
        tick(1, 0, 0); tick(0, 0, 0);
    endtask

    initial begin
        logic [31:0] pat;
        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; BSChainTDO = 1'b0;
        cnt_cap = 0; cnt_sh = 0; cnt_upd = 0;
        #12;
        chk("rst_state", 32'(dut.w_state), 32'hF);
        chk("rst_ir", 32'(dut.r_ir), 32'h2);
        chk("rst_tdo", 32'(TDO), 32'd0);
        chk("rst_tdo_en", 32'(TDO_en), 32'd0);
        chk("rst_strobes", {29'd0, CaptureDR, ShiftDR, UpdateDR}, 32'd0);
        chk("rst_extest", 32'(extest), 32'd0);
        @(negedge TCK); #1; TRST = 1'b1;
        tick(1, 0, 0);
        chk("tlr_hold", 32'(dut.w_state), 32'hF);
        tick(0, 0, 0);
        chk("first_tms0_rti", 32'(dut.w_state), 32'hC);

        // IDCODE selected after reset: 32 bits LSB first, no boundary strobes.
        sb_tag = "idcode_tdo";
        for (int i = 0; i < 32; i++) sb.push_back(32'(IDCODE[i]));
        dr_scan(32, 32'h0, 32'h0);
        chk("idcode_strobes", 32'(cnt_cap + cnt_sh + cnt_upd), 32'd0);

        load_ir(4'b0000);

        // SAMPLE/PRELOAD: boundary chain drives TDO, strobes fire once per state.
        load_ir(4'b0001);
        pat = 32'b1101;
        sb_tag = "bsc_tdo";
        for (int i = 0; i < 4; i++) sb.push_back(32'(pat[i]));
        dr_scan(4, 32'h0, pat);
        chk("bsc_capture_cnt", 32'(cnt_cap), 32'd1);
        chk("bsc_shift_cnt", 32'(cnt_sh), 32'd4);
        chk("bsc_update_cnt", 32'(cnt_upd), 32'd1);
        chk("sample_extest", 32'(extest), 32'd0);

        // BYPASS and an unassigned opcode: TDO is TDI delayed one TCK.
        for (int k = 0; k < 2; k++) begin
            pat = (k == 0) ? 32'b11101 : 32'b10110;
            load_ir((k == 0) ? 4'b1111 : 4'b0101);
            sb_tag = (k == 0) ? "bypass_tdo" : "unknown_op_tdo";
            sb.push_back(32'd0);
            for (int i = 0; i < 4; i++) sb.push_back(32'(pat[i]));
            dr_scan(5, pat, 32'hFFFF_FFFF);
            chk("bypass_strobes", 32'(cnt_cap + cnt_sh + cnt_upd), 32'd0);
        end

        // Pause-IR, then five TMS=1 reach TLR, which reloads IDCODE.
        sb_tag = "pause_ir_tdo";
        sb.push_back(32'd1);
        tick(1, 0, 0); tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
        tick(1, 1, 0); tick(0, 0, 0);
        chk("pause_ir", 32'(dut.w_state), 32'hB);
        for (int i = 0; i < 5; i++) tick(1, 0, 0);
        chk("tms5_tlr", 32'(dut.w_state), 32'hF);
        chk("tlr_reload_ir", 32'(dut.r_ir), 32'h2);
        tick(0, 0, 0);
        chk("tms0_rti", 32'(dut.w_state), 32'hC);

        // TRST in the middle of an EXTEST Shift-DR.
        load_ir(4'b0000);
        sb_tag = "trst_bsc_tdo";
        sb.push_back(32'd1); sb.push_back(32'd0);
        tick(1, 0, 0); tick(0, 0, 0); tick(0, 0, 1); tick(0, 0, 0);
        chk("shiftdr_before_trst", 32'(ShiftDR), 32'd1);
        #2; TRST = 1'b0; #1;
        chk("trst_state", 32'(dut.w_state), 32'hF);
        chk("trst_ir", 32'(dut.r_ir), 32'h2);
        chk("trst_strobes", {29'd0, CaptureDR, ShiftDR, UpdateDR}, 32'd0);
        chk("trst_extest", 32'(extest), 32'd0);
        chk("trst_tdo_en", 32'(TDO_en), 32'd0);
        @(negedge TCK); #1; TRST = 1'b1; exp_ext = 1'b0;
        cnt_upd = 0;
        tick(0, 0, 0);
        chk("post_trst_rti", 32'(dut.w_state), 32'hC);
        tick(0, 0, 0);
        chk("no_update_after_abort", 32'(cnt_upd), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
